// File: rtl/sarray_pkg.sv
// Shared constants, FSM encoding and precision codes for the systolic array feed path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sarray_pkg;

    localparam int SARRAY_H = 8;
    localparam int SARRAY_W = 8;
    localparam int CNT_W    = 8;
    localparam int PREC_W   = 2;
    localparam int LOAD_W   = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_t;

    localparam logic [PREC_W-1:0] PREC_INT8  = 2'd0;
    localparam logic [PREC_W-1:0] PREC_INT16 = 2'd1;
    localparam logic [PREC_W-1:0] PREC_FP16  = 2'd2;
    localparam logic [PREC_W-1:0] PREC_BF16  = 2'd3;

    // Cycles spent in DRAIN counting down to zero: last operand lands after the
    // read latency, then crosses both skew banks and the PE pipeline.
    function automatic int drain_init(input int rd_lat, input int h, input int w, input int extra);
        return rd_lat + h + w + extra - 1;
    endfunction

endpackage

// File: rtl/sarray_feed_align.sv
// Delays the per-beat valid/cnt tag so it lines up with operand buffer read data.
// Latency: RD_LAT cycles, fixed.
// Backpressure: none; the pipe always advances. Ports: clk, rst_n, in_vld/in_cnt -> out_vld/out_cnt.
module sarray_feed_align #(
    parameter int CNT_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [CNT_W-1:0] in_cnt,
    output logic             out_vld,
    output logic [CNT_W-1:0] out_cnt
);

    logic [RD_LAT-1:0]            vld_pipe;
    logic [RD_LAT-1:0][CNT_W-1:0] cnt_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            cnt_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            cnt_pipe[0] <= in_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                cnt_pipe[i] <= cnt_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[RD_LAT-1];
    assign out_cnt = cnt_pipe[RD_LAT-1];

endmodule

// File: rtl/sarray_feed_ctrl.sv
// Sequences one TMMA tile: reads K A/B beats, feeds left/top skew banks with tags, drains, pulses done_o.
// Latency: command-to-done = K + RD_LAT + SARRAY_H + SARRAY_W + DRAIN_EXTRA + 1 cycles (K=0: 1 cycle).
// Backpressure: cmd_ready_o only in IDLE; source holds the command. Optional SARRAY_FEED_PERF_EN adds perf counters.
module sarray_feed_ctrl #(
    parameter int SARRAY_H    = sarray_pkg::SARRAY_H,
    parameter int SARRAY_W    = sarray_pkg::SARRAY_W,
    parameter int CNT_W       = sarray_pkg::CNT_W,
    parameter int PREC_W      = sarray_pkg::PREC_W,
    parameter int LOAD_W      = sarray_pkg::LOAD_W,
    parameter int ADDR_W      = 10,
    parameter int RD_LAT      = 1,
    parameter int DRAIN_EXTRA = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CNT_W-1:0]  cmd_k_i,
    input  logic [ADDR_W-1:0] cmd_a_base_i,
    input  logic [ADDR_W-1:0] cmd_b_base_i,
    input  logic              cmd_type_i,
    input  logic [PREC_W-1:0] cmd_precision_i,
    input  logic              cmd_acc_i,
    output logic              a_rd_en_o,
    output logic [ADDR_W-1:0] a_rd_addr_o,
    input  logic [LOAD_W-1:0] a_rd_data_i,
    output logic              b_rd_en_o,
    output logic [ADDR_W-1:0] b_rd_addr_o,
    input  logic [LOAD_W-1:0] b_rd_data_i,
    output logic              left_valid_o,
    output logic [CNT_W-1:0]  left_cnt_o,
    output logic              left_type_o,
    output logic [PREC_W-1:0] left_precision_o,
    output logic              left_acc_o,
    output logic [LOAD_W-1:0] left_data_o,
    output logic              top_valid_o,
    output logic [CNT_W-1:0]  top_cnt_o,
    output logic [LOAD_W-1:0] top_data_o,
    output logic              busy_o,
    output logic              done_o
`ifdef SARRAY_FEED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cycles_o,
    output logic [15:0]       perf_cmds_o
`endif
);

    import sarray_pkg::*;

    localparam int DRAIN_INIT = drain_init(RD_LAT, SARRAY_H, SARRAY_W, DRAIN_EXTRA);
    localparam int DRAIN_W    = $clog2(DRAIN_INIT + 1);

    feed_state_t       state_q, state_d;
    logic [CNT_W-1:0]  k_q, beat_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q;
    logic              type_q, acc_q;
    logic [PREC_W-1:0] prec_q;

    logic              accept, feeding, last_beat;
    logic              al_vld;
    logic [CNT_W-1:0]  al_cnt;

    assign accept    = cmd_valid_i && (state_q == ST_IDLE);
    assign feeding   = (state_q == ST_FEED);
    assign last_beat = (beat_q == (k_q - CNT_W'(1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid_i) state_d = (cmd_k_i == '0) ? ST_DONE : ST_FEED;
            ST_FEED:  if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            type_q   <= 1'b0;
            prec_q   <= '0;
            acc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q      <= cmd_k_i;
                beat_q   <= '0;
                a_base_q <= cmd_a_base_i;
                b_base_q <= cmd_b_base_i;
                type_q   <= cmd_type_i;
                prec_q   <= cmd_precision_i;
                acc_q    <= cmd_acc_i;
            end else if (feeding) begin
                beat_q <= beat_q + CNT_W'(1);
            end
            // Counter is loaded as FEED hands over, so DRAIN starts at full count.
            if (feeding && last_beat) begin
                drain_q <= DRAIN_W'(DRAIN_INIT);
            end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
                drain_q <= drain_q - DRAIN_W'(1);
            end
        end
    end

    // Addresses wrap naturally at 2^ADDR_W through the adder width.
    assign a_rd_en_o   = feeding;
    assign b_rd_en_o   = feeding;
    assign a_rd_addr_o = feeding ? (a_base_q + ADDR_W'(beat_q)) : '0;
    assign b_rd_addr_o = feeding ? (b_base_q + ADDR_W'(beat_q)) : '0;

    sarray_feed_align #(
        .CNT_W  (CNT_W),
        .RD_LAT (RD_LAT)
    ) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (feeding),
        .in_cnt  (beat_q),
        .out_vld (al_vld),
        .out_cnt (al_cnt)
    );

    assign left_valid_o     = al_vld;
    assign left_cnt_o       = al_vld ? al_cnt : '0;
    assign left_type_o      = al_vld & type_q;
    assign left_precision_o = al_vld ? prec_q : '0;
    assign left_acc_o       = al_vld & acc_q;
    assign left_data_o      = al_vld ? a_rd_data_i : '0;
    assign top_valid_o      = al_vld;
    assign top_cnt_o        = al_vld ? al_cnt : '0;
    assign top_data_o       = al_vld ? b_rd_data_i : '0;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

`ifdef SARRAY_FEED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles_o <= '0;
            perf_cmds_o        <= '0;
        end else begin
            if (busy_o && (perf_busy_cycles_o != '1)) perf_busy_cycles_o <= perf_busy_cycles_o + 32'd1;
            if (accept && (perf_cmds_o != '1))        perf_cmds_o        <= perf_cmds_o + 16'd1;
        end
    end
`endif

endmodule
